// File: rtl/power_sequencer_pkg.sv
// Shared definitions for the power sequencer: FSM state type and default
// timing constants (derived from the 100 MHz system clock).
package power_sequencer_pkg;

  typedef enum logic [2:0] {
    OFF,
    UP_ACK,
    UP_DLY,
    ON,
    DN_ACK,
    DN_DLY,
    FAULT
  } pwr_seq_state_t;

  localparam int CLK_HZ          = 100_000_000;
  localparam int DEF_STEP_DELAY  = CLK_HZ;      // 1 s settle per stage
  localparam int DEF_ACK_TIMEOUT = CLK_HZ / 2;  // 0.5 s ack window

endpackage

// File: rtl/power_sequencer_seq_timer.sv
// seq_timer: loadable down-counter shared by the settle delay and the ack
// timeout (the two are never active at the same time).
// Ports:
//   clk, rst  - clock, async active-low reset
//   load      - load `value` into the counter this cycle
//   value     - count to load
//   done      - counter has reached zero (holds at zero)
module seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                count <= '0;
    else if (load)           count <= value;
    else if (count != '0)    count <= count - CNT_W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/power_sequencer.sv
// power_sequencer: ordered power-up / power-down of NUM_STAGES subsystems.
// Each stage is enabled, its acknowledge awaited (bounded by ACK_TIMEOUT),
// then a STEP_DELAY settle runs before the next stage. Power-down walks the
// stages in reverse. A missing ack latches FAULT with every enable dropped.
// Ports:
//   clk, rst      - 100 MHz clock, async active-low reset
//   power_status  - requested power state (1 = on)
//   clear_fault   - pulse; leaves FAULT only while power_status = 0
//   stage_ack     - per-stage acknowledge level
//   stage_en      - per-stage enable (registered, contiguous from bit 0)
//   sys_ready     - all stages up and settled
//   busy          - sequencing in progress
//   fault         - ack timeout latched
//   fault_stage   - stage index that timed out
module power_sequencer
  import power_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STEP_DELAY  = DEF_STEP_DELAY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          power_status,
  input  logic                          clear_fault,
  input  logic [NUM_STAGES-1:0]         stage_ack,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic                          sys_ready,
  output logic                          busy,
  output logic                          fault,
  output logic [$clog2(NUM_STAGES)-1:0] fault_stage
);

  localparam int               IW    = $clog2(NUM_STAGES);
  localparam logic [IW-1:0]    TOP   = IW'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] T_ACK = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] T_DLY = CNT_W'(STEP_DELAY);

  pwr_seq_state_t        state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [NUM_STAGES-1:0] en_nxt;
  logic                  tmr_load, tmr_done;
  logic [CNT_W-1:0]      tmr_value;

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // State, stage index and enables all move together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= OFF;
      idx      <= '0;
      stage_en <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      stage_en <= en_nxt;
    end
  end

  // Timer is loaded with T_ACK on every enable/disable edge and with T_DLY
  // on every accepted ack. Timeout has priority over a same-cycle ack, so an
  // ack is accepted up to and including ACK_TIMEOUT edges after the enable.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    en_nxt    = stage_en;
    tmr_load  = 1'b0;
    tmr_value = T_ACK;
    unique case (state)
      OFF: if (power_status) begin
        idx_nxt   = '0;
        en_nxt[0] = 1'b1;
        tmr_load  = 1'b1;
        state_nxt = UP_ACK;
      end
      UP_ACK, UP_DLY: begin
        if (!power_status) begin
          // abort: drop the stage in flight, unwind from here
          en_nxt[idx] = 1'b0;
          tmr_load    = 1'b1;
          state_nxt   = DN_ACK;
        end else if (state == UP_ACK) begin
          if (tmr_done) begin
            en_nxt    = '0;
            state_nxt = FAULT;
          end else if (stage_ack[idx]) begin
            tmr_load  = 1'b1;
            tmr_value = T_DLY;
            state_nxt = UP_DLY;
          end
        end else if (tmr_done) begin
          if (idx == TOP) begin
            state_nxt = ON;
          end else begin
            idx_nxt         = idx + IW'(1);
            en_nxt[idx_nxt] = 1'b1;
            tmr_load        = 1'b1;
            state_nxt       = UP_ACK;
          end
        end
      end
      ON: if (!power_status) begin
        idx_nxt     = TOP;
        en_nxt[TOP] = 1'b0;
        tmr_load    = 1'b1;
        state_nxt   = DN_ACK;
      end
      // power_status is not looked at while going down
      DN_ACK: begin
        if (tmr_done) begin
          en_nxt    = '0;
          state_nxt = FAULT;
        end else if (!stage_ack[idx]) begin
          tmr_load  = 1'b1;
          tmr_value = T_DLY;
          state_nxt = DN_DLY;
        end
      end
      DN_DLY: if (tmr_done) begin
        if (idx == '0) begin
          state_nxt = OFF;
        end else begin
          idx_nxt         = idx - IW'(1);
          en_nxt[idx_nxt] = 1'b0;
          tmr_load        = 1'b1;
          state_nxt       = DN_ACK;
        end
      end
      FAULT: begin
        en_nxt = '0;
        if (clear_fault && !power_status) state_nxt = OFF;
      end
      default: begin
        en_nxt    = '0;
        state_nxt = OFF;
      end
    endcase
  end

  // Status decodes of the registered state; idx is frozen while in FAULT.
  always_comb begin
    sys_ready   = (state == ON);
    busy        = state inside {UP_ACK, UP_DLY, DN_ACK, DN_DLY};
    fault       = (state == FAULT);
    fault_stage = (state == FAULT) ? idx : '0;
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer (3 stages, STEP_DELAY=4, ACK_TIMEOUT=10).
// Acks follow enables through one flop (sampled two edges after the enable
// edge), with optional stuck-low / stuck-high overrides for fault cases.
// A timestamp-based reference model predicts every output each cycle.
module tb_power_sequencer;

  localparam int N = 3;
  localparam int D = 4;
  localparam int T = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         power_status, clear_fault;
  logic [N-1:0] stage_ack, stage_en, en_q, stuck_lo, stuck_hi;
  logic         sys_ready, busy, fault;
  logic [1:0]   fault_stage;
  logic [7:0]   dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  power_sequencer #(.NUM_STAGES(N), .STEP_DELAY(D), .ACK_TIMEOUT(T), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .power_status (power_status),
    .clear_fault  (clear_fault),
    .stage_ack    (stage_ack),
    .stage_en     (stage_en),
    .sys_ready    (sys_ready),
    .busy         (busy),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  // Subsystem model: each stage reports its enable one cycle later.
  always @(posedge clk or negedge rst)
    if (!rst) en_q <= '0;
    else      en_q <= stage_en;
  assign stage_ack = (en_q & ~stuck_lo) | stuck_hi;
  assign dut_vec   = {stage_en, sys_ready, busy, fault, fault_stage};

  // Reference model: number of enabled stages plus absolute-cycle deadlines.
  localparam int M_OFF = 0, M_UPW = 1, M_UPS = 2, M_ON = 3, M_DNW = 4, M_DNS = 5, M_FLT = 6;
  int m_mode, m_lvl, m_cur, cyc, dl, se;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= M_OFF; m_lvl <= 0; m_cur <= 0; cyc <= 0; dl <= 0; se <= 0;
    end else begin
      cyc <= cyc + 1;
      case (m_mode)
        M_OFF: if (power_status) begin
          m_lvl <= 1; m_cur <= 0; m_mode <= M_UPW; dl <= cyc + T;
        end
        M_UPW, M_UPS: begin
          if (!power_status) begin
            m_lvl <= m_cur; m_mode <= M_DNW; dl <= cyc + T;
          end else if (m_mode == M_UPW) begin
            if (cyc > dl) begin m_lvl <= 0; m_mode <= M_FLT; end
            else if (stage_ack[m_cur]) begin m_mode <= M_UPS; se <= cyc + 1 + D; end
          end else if (cyc == se) begin
            if (m_cur == N - 1) m_mode <= M_ON;
            else begin m_cur <= m_cur + 1; m_lvl <= m_cur + 2; m_mode <= M_UPW; dl <= cyc + T; end
          end
        end
        M_ON: if (!power_status) begin
          m_lvl <= N - 1; m_cur <= N - 1; m_mode <= M_DNW; dl <= cyc + T;
        end
        M_DNW: begin
          if (cyc > dl) begin m_lvl <= 0; m_mode <= M_FLT; end
          else if (!stage_ack[m_cur]) begin m_mode <= M_DNS; se <= cyc + 1 + D; end
        end
        M_DNS: if (cyc == se) begin
          if (m_cur == 0) m_mode <= M_OFF;
          else begin m_cur <= m_cur - 1; m_lvl <= m_cur - 1; m_mode <= M_DNW; dl <= cyc + T; end
        end
        M_FLT: if (clear_fault && !power_status) m_mode <= M_OFF;
        default: m_mode <= M_OFF;
      endcase
    end
  end

  function automatic logic [7:0] exp_vec();
    logic [N-1:0] e;
    logic         b;
    e = N'((1 << m_lvl) - 1);
    b = (m_mode == M_UPW) || (m_mode == M_UPS) || (m_mode == M_DNW) || (m_mode == M_DNS);
    return {e, (m_mode == M_ON), b, (m_mode == M_FLT), (m_mode == M_FLT) ? 2'(m_cur) : 2'd0};
  endfunction

  task automatic test_reset();
    power_status = 0; clear_fault = 0; stuck_lo = '0; stuck_hi = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_vec !== 8'h00) begin n_bad++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 8'h00); end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL reset_idle got=%b exp=%b", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_power_up();
    logic [N-1:0] e;
    power_status = 1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL up_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
      e = (k < 8) ? 3'b001 : (k < 15) ? 3'b011 : 3'b111;
      n_cmp++;
      if (stage_en !== e) begin n_bad++; $display("FAIL up_step k=%0d got=%b exp=%b", k, stage_en, e); end
      n_cmp++;
      if (sys_ready !== (k >= 22)) begin n_bad++; $display("FAIL up_ready k=%0d got=%b exp=%b", k, sys_ready, k >= 22); end
      n_cmp++;
      if (busy !== (k <= 21)) begin n_bad++; $display("FAIL up_busy k=%0d got=%b exp=%b", k, busy, k <= 21); end
    end
  endtask

  task automatic test_power_down();
    logic [N-1:0] e;
    power_status = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL dn_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
      e = (k < 8) ? 3'b011 : (k < 15) ? 3'b001 : 3'b000;
      n_cmp++;
      if (stage_en !== e || sys_ready !== 1'b0) begin
        n_bad++; $display("FAIL dn_step k=%0d got=%b/%b exp=%b/0", k, stage_en, sys_ready, e);
      end
      n_cmp++;
      if (busy !== (k <= 21)) begin n_bad++; $display("FAIL dn_busy k=%0d got=%b exp=%b", k, busy, k <= 21); end
    end
  endtask

  task automatic test_abort();
    power_status = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL abort_up k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
    end
    n_cmp++;
    if (stage_en !== 3'b011) begin n_bad++; $display("FAIL abort_pre got=%b exp=011", stage_en); end
    power_status = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL abort_dn k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
      if (k == 1) begin
        n_cmp++;
        if (stage_en !== 3'b001) begin n_bad++; $display("FAIL abort_first got=%b exp=001", stage_en); end
      end
      n_cmp++;
      if (sys_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready k=%0d got=%b exp=0", k, sys_ready); end
    end
    n_cmp++;
    if (stage_en !== 3'b000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_end got=%b/%b exp=000/0", stage_en, busy);
    end
  endtask

  task automatic test_timeout();
    stuck_lo = 3'b010;
    power_status = 1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL to_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
    end
    n_cmp++;
    if ({stage_en, fault, fault_stage} !== {3'b000, 1'b1, 2'd1}) begin
      n_bad++; $display("FAIL to_fault got=%b/%b/%0d exp=000/1/1", stage_en, fault, fault_stage);
    end
    clear_fault = 1;
    @(negedge clk);
    clear_fault = 0;
    n_cmp++;
    if (fault !== 1'b1 || dut_vec !== exp_vec()) begin n_bad++; $display("FAIL to_clr_ignored got=%b exp=%b", dut_vec, exp_vec()); end
    power_status = 0;
    @(negedge clk);
    n_cmp++;
    if (fault !== 1'b1) begin n_bad++; $display("FAIL to_hold got=%b exp=1", fault); end
    clear_fault = 1;
    @(negedge clk);
    clear_fault = 0;
    n_cmp++;
    if (dut_vec !== 8'h00 || dut_vec !== exp_vec()) begin n_bad++; $display("FAIL to_clear got=%b exp=%b", dut_vec, 8'h00); end
    stuck_lo = '0;
  endtask

  task automatic test_rerequest();
    int seen_off;
    power_status = 1;
    repeat (24) @(negedge clk);
    n_cmp++;
    if (sys_ready !== 1'b1) begin n_bad++; $display("FAIL rr_on got=%b exp=1", sys_ready); end
    power_status = 0;
    repeat (10) @(negedge clk);
    power_status = 1;
    @(negedge clk);
    power_status = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rr_pulse k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
    end
    n_cmp++;
    if (stage_en !== 3'b000 || busy !== 1'b0) begin n_bad++; $display("FAIL rr_done got=%b/%b exp=000/0", stage_en, busy); end
    // hold the request through power-down: restart right after OFF
    power_status = 1;
    repeat (24) @(negedge clk);
    power_status = 0;
    repeat (3) @(negedge clk);
    power_status = 1;
    seen_off = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rr_hold k=%0d got=%b exp=%b", k, dut_vec, exp_vec()); end
      if (seen_off >= 0 && k == seen_off + 1) begin
        n_cmp++;
        if (stage_en !== 3'b001 || busy !== 1'b1) begin n_bad++; $display("FAIL rr_restart got=%b/%b exp=001/1", stage_en, busy); end
      end
      if (seen_off < 0 && busy === 1'b0) seen_off = k;
    end
    n_cmp++;
    if (seen_off < 0) begin n_bad++; $display("FAIL rr_reach_off got=never exp=OFF within 40 cycles"); end
    power_status = 0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_async_reset();
    power_status = 1;
    repeat (24) @(negedge clk);
    n_cmp++;
    if (stage_en !== 3'b111) begin n_bad++; $display("FAIL ar_pre got=%b exp=111", stage_en); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 8'h00) begin n_bad++; $display("FAIL ar_immediate got=%b exp=%b", dut_vec, 8'h00); end
    power_status = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== 8'h00 || dut_vec !== exp_vec()) begin n_bad++; $display("FAIL ar_off got=%b exp=%b", dut_vec, 8'h00); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      power_status = 1'($urandom_range(0, 1));
      stuck_lo = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '0;
      stuck_hi = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '0;
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
        clear_fault = ($urandom_range(0, 9) == 0);
        @(negedge clk);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rand it=%0d got=%b exp=%b", it, dut_vec, exp_vec()); end
      end
    end
    clear_fault = 0; stuck_lo = '0; stuck_hi = '0; power_status = 0;
    repeat (30) @(negedge clk);
    clear_fault = 1;
    @(negedge clk);
    clear_fault = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rand_drain got=%b exp=%b", dut_vec, exp_vec()); end
    end
    n_cmp++;
    if (dut_vec !== 8'h00) begin n_bad++; $display("FAIL rand_final got=%b exp=%b", dut_vec, 8'h00); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_timeout();
    test_rerequest();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
